// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between the CPU
// multicycle FSM and the debug/loader port. Arbitration happens only in IDLE,
// and each access holds mem_en for WAIT_CYCLES cycles.
// Optional build macro: ARB_STARVE_GUARD_EN. When it is defined, the debug
// port is forced to win after STARVE_LIMIT consecutive lost rounds.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate on cpu_req/dbg_req
// ACCESS | memory command driven from latched values, counting wait cycles
// DONE   | one-cycle ack to the owner, memory idle
module unified_mem_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    // Reject illegal parameter values at elaboration.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        owner;      // 0 = CPU, 1 = debug
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        force_dbg;
    logic        grant_dbg;

    // Debug wins only if the CPU is silent or the starvation guard trips.
    assign grant_dbg = dbg_req && (!cpu_req || force_dbg);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign force_dbg = (starve_cnt == STARVE_MAX);

    // Count consecutive rounds debug loses; clear on a debug win or no debug request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (!dbg_req || grant_dbg) begin
                starve_cnt <= 4'd0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign force_dbg = 1'b0;
`endif

    // Main sequencer: arbitrate and latch the winner, count the access, capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            dbg_rdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        state     <= ST_ACCESS;
                        cnt       <= 4'd0;
                        owner     <= grant_dbg;
                        lat_we    <= grant_dbg ? dbg_we    : cpu_we;
                        lat_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                        lat_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        state <= ST_DONE;
                        cnt   <= 4'd0;
                        // Captured for writes too; the requester just ignores it.
                        if (owner) begin
                            dbg_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory command and acks decode straight from state so reset clears them at once.
    always_comb begin
        mem_en    = (state == ST_ACCESS);
        mem_we    = (state == ST_ACCESS) && lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        cpu_ack   = (state == ST_DONE) && !owner;
        dbg_ack   = (state == ST_DONE) && owner;
        busy      = (state != ST_IDLE);
    end

endmodule
